// File: rtl/regwb_sched_if.sv
// Handshake and register-file bundle for the write-back scheduler.
// master = producers/decode/register-file side, slave = the scheduler itself.
interface regwb_sched_if;
  logic        iStall;
  logic        iAluValid;
  logic [4:0]  iAluAddr;
  logic [31:0] iAluData;
  logic        oAluReady;
  logic        iMemValid;
  logic [4:0]  iMemAddr;
  logic [31:0] iMemData;
  logic        oMemReady;
  logic        iLnkValid;
  logic [31:0] iLnkData;
  logic        oLnkReady;
  logic        iRsvValid;
  logic [4:0]  iRsvAddr;
  logic [4:0]  iAddrA;
  logic [4:0]  iAddrB;
  logic        oBusyA;
  logic        oBusyB;
  logic        oWrite;
  logic [4:0]  oAddrC;
  logic [31:0] oRegC;

  modport master (
    output iStall, iAluValid, iAluAddr, iAluData, iMemValid, iMemAddr, iMemData,
           iLnkValid, iLnkData, iRsvValid, iRsvAddr, iAddrA, iAddrB,
    input  oAluReady, oMemReady, oLnkReady, oBusyA, oBusyB, oWrite, oAddrC, oRegC
  );

  modport slave (
    input  iStall, iAluValid, iAluAddr, iAluData, iMemValid, iMemAddr, iMemData,
           iLnkValid, iLnkData, iRsvValid, iRsvAddr, iAddrA, iAddrB,
    output oAluReady, oMemReady, oLnkReady, oBusyA, oBusyB, oWrite, oAddrC, oRegC
  );
endinterface

// File: rtl/regwb_sched.sv
// Write-back scheduler: round-robin arbitration of ALU / MEM / LNK onto the
// single register-file write port, registered write stage, and a destination
// scoreboard that flags read-after-write hazards for both decode read ports.
module regwb_sched #(
  parameter logic [4:0] LNK_ADDR = 5'd31
) (
  input  logic          iClk,
  input  logic          nRst,
  regwb_sched_if.slave  bus
);

  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] busy_q, busy_d;
  logic        write_q, write_d;
  logic [4:0]  addr_c_q, addr_c_d;
  logic [31:0] reg_c_q, reg_c_d;

  logic [3:0]  req_vld;
  logic [1:0]  cand1, cand2;
  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;

  // Requester index successor, wrapping 2 -> 0 (pointer never holds 3).
  function automatic logic [1:0] inc3(input logic [1:0] k);
    return (k == 2'd2) ? 2'd0 : k + 2'd1;
  endfunction

  // Round-robin search starting at ptr; nothing is granted in stall or reset.
  always_comb begin
    req_vld = {1'b0, bus.iLnkValid, bus.iMemValid, bus.iAluValid};
    cand1   = inc3(ptr_q);
    cand2   = inc3(cand1);
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    if (nRst && !bus.iStall) begin
      if (req_vld[ptr_q]) begin
        gnt_vld = 1'b1;
        gnt_idx = ptr_q;
      end else if (req_vld[cand1]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand1;
      end else if (req_vld[cand2]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand2;
      end
    end
  end

  // Destination/data of the granted requester; link writes always target LNK_ADDR.
  always_comb begin
    gnt_addr = bus.iAluAddr;
    gnt_data = bus.iAluData;
    case (gnt_idx)
      2'd1: begin
        gnt_addr = bus.iMemAddr;
        gnt_data = bus.iMemData;
      end
      2'd2: begin
        gnt_addr = LNK_ADDR;
        gnt_data = bus.iLnkData;
      end
      default: begin
        gnt_addr = bus.iAluAddr;
        gnt_data = bus.iAluData;
      end
    endcase
  end

  assign bus.oAluReady = gnt_vld && (gnt_idx == 2'd0);
  assign bus.oMemReady = gnt_vld && (gnt_idx == 2'd1);
  assign bus.oLnkReady = gnt_vld && (gnt_idx == 2'd2);

  // Next pointer, write stage and scoreboard; a same-cycle reservation
  // overrides the clear so the newer outstanding write stays visible.
  always_comb begin
    ptr_d    = ptr_q;
    write_d  = 1'b0;
    addr_c_d = addr_c_q;
    reg_c_d  = reg_c_q;
    busy_d   = busy_q;
    if (gnt_vld) begin
      ptr_d            = inc3(gnt_idx);
      busy_d[gnt_addr] = 1'b0;
      if (gnt_addr != 5'd0) begin
        write_d  = 1'b1;
        addr_c_d = gnt_addr;
        reg_c_d  = gnt_data;
      end
    end
    if (bus.iRsvValid && (bus.iRsvAddr != 5'd0)) begin
      busy_d[bus.iRsvAddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset clears everything, including an in-flight write.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      ptr_q    <= 2'd0;
      busy_q   <= '0;
      write_q  <= 1'b0;
      addr_c_q <= 5'd0;
      reg_c_q  <= 32'd0;
    end else begin
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      write_q  <= write_d;
      addr_c_q <= addr_c_d;
      reg_c_q  <= reg_c_d;
    end
  end

  assign bus.oBusyA = busy_q[bus.iAddrA];
  assign bus.oBusyB = busy_q[bus.iAddrB];
  assign bus.oWrite = write_q;
  assign bus.oAddrC = addr_c_q;
  assign bus.oRegC  = reg_c_q;

endmodule

// File: tb/tb_regwb_sched.sv
// Directed bench for regwb_sched: arbitration order, write stage, scoreboard,
// stall and asynchronous reset behaviour.
module tb_regwb_sched;

  logic clk = 1'b0;
  logic nRst;
  int   n_pass  = 0;
  int   n_total = 0;

  regwb_sched_if bus();

  regwb_sched #(.LNK_ADDR(5'd31)) dut (
    .iClk (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic clr_inputs();
    bus.iStall    = 1'b0;
    bus.iAluValid = 1'b0;
    bus.iAluAddr  = 5'd0;
    bus.iAluData  = 32'd0;
    bus.iMemValid = 1'b0;
    bus.iMemAddr  = 5'd0;
    bus.iMemData  = 32'd0;
    bus.iLnkValid = 1'b0;
    bus.iLnkData  = 32'd0;
    bus.iRsvValid = 1'b0;
    bus.iRsvAddr  = 5'd0;
    bus.iAddrA    = 5'd0;
    bus.iAddrB    = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    #2;
    nRst = 1'b1;
  endtask

  task automatic test_reset();
    clr_inputs();
    bus.iAluValid = 1'b1;
    bus.iMemValid = 1'b1;
    #2;
    n_total++;
    if ({bus.oLnkReady, bus.oMemReady, bus.oAluReady} !== 3'b000)
      $display("FAIL rst_ready act=%b exp=000", {bus.oLnkReady, bus.oMemReady, bus.oAluReady});
    else n_pass++;
    tick();
    tick();
    clr_inputs();
    nRst = 1'b1;
    #1;
    n_total++;
    if (bus.oWrite !== 1'b0) $display("FAIL rst_write act=%b exp=0", bus.oWrite);
    else n_pass++;
    n_total++;
    if (bus.oAddrC !== 5'd0) $display("FAIL rst_addr act=%0d exp=0", bus.oAddrC);
    else n_pass++;
    n_total++;
    if (bus.oRegC !== 32'd0) $display("FAIL rst_data act=%h exp=0", bus.oRegC);
    else n_pass++;
    n_total++;
    if ({bus.oBusyA, bus.oBusyB} !== 2'b00) $display("FAIL rst_busy act=%b exp=00", {bus.oBusyA, bus.oBusyB});
    else n_pass++;
    tick();
  endtask

  task automatic test_single_alu();
    bus.iAluValid = 1'b1;
    bus.iAluAddr  = 5'd5;
    bus.iAluData  = 32'hDEADBEEF;
    #1;
    n_total++;
    if ({bus.oLnkReady, bus.oMemReady, bus.oAluReady} !== 3'b001)
      $display("FAIL alu_ready act=%b exp=001", {bus.oLnkReady, bus.oMemReady, bus.oAluReady});
    else n_pass++;
    tick();
    clr_inputs();
    n_total++;
    if (bus.oWrite !== 1'b1 || bus.oAddrC !== 5'd5 || bus.oRegC !== 32'hDEADBEEF)
      $display("FAIL alu_write act=%b/%0d/%h exp=1/5/deadbeef", bus.oWrite, bus.oAddrC, bus.oRegC);
    else n_pass++;
    tick();
    n_total++;
    if (bus.oWrite !== 1'b0 || bus.oAddrC !== 5'd5)
      $display("FAIL alu_pulse act=%b/%0d exp=0/5", bus.oWrite, bus.oAddrC);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [4:0]  addr_tab [3];
    logic [31:0] data_tab [3];
    logic [2:0]  exp_rdy;
    addr_tab = '{5'd1, 5'd2, 5'd31};
    data_tab = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
    do_reset();
    bus.iAluValid = 1'b1;
    bus.iAluAddr  = addr_tab[0];
    bus.iAluData  = data_tab[0];
    bus.iMemValid = 1'b1;
    bus.iMemAddr  = addr_tab[1];
    bus.iMemData  = data_tab[1];
    bus.iLnkValid = 1'b1;
    bus.iLnkData  = data_tab[2];
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy = 3'b001 << (i % 3);
      n_total++;
      if ({bus.oLnkReady, bus.oMemReady, bus.oAluReady} !== exp_rdy)
        $display("FAIL rr_ready[%0d] act=%b exp=%b", i, {bus.oLnkReady, bus.oMemReady, bus.oAluReady}, exp_rdy);
      else n_pass++;
      tick();
      n_total++;
      if (bus.oWrite !== 1'b1 || bus.oAddrC !== addr_tab[i % 3] || bus.oRegC !== data_tab[i % 3])
        $display("FAIL rr_write[%0d] act=%b/%0d/%h exp=1/%0d/%h", i, bus.oWrite, bus.oAddrC, bus.oRegC,
                 addr_tab[i % 3], data_tab[i % 3]);
      else n_pass++;
    end
    clr_inputs();
  endtask

  task automatic test_r0();
    bus.iMemValid = 1'b1;
    bus.iMemAddr  = 5'd0;
    bus.iMemData  = 32'h5555_5555;
    #1;
    n_total++;
    if (bus.oMemReady !== 1'b1) $display("FAIL r0_ready act=%b exp=1", bus.oMemReady);
    else n_pass++;
    tick();
    clr_inputs();
    n_total++;
    if (bus.oWrite !== 1'b0) $display("FAIL r0_write act=%b exp=0", bus.oWrite);
    else n_pass++;
    bus.iRsvValid = 1'b1;
    bus.iRsvAddr  = 5'd0;
    bus.iAddrA    = 5'd0;
    tick();
    bus.iRsvValid = 1'b0;
    n_total++;
    if (bus.oBusyA !== 1'b0) $display("FAIL r0_busy act=%b exp=0", bus.oBusyA);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    bus.iRsvValid = 1'b1;
    bus.iRsvAddr  = 5'd7;
    bus.iAddrA    = 5'd7;
    bus.iAddrB    = 5'd7;
    #1;
    n_total++;
    if (bus.oBusyA !== 1'b0) $display("FAIL sb_same_cycle act=%b exp=0", bus.oBusyA);
    else n_pass++;
    tick();
    bus.iRsvValid = 1'b0;
    n_total++;
    if (bus.oBusyA !== 1'b1) $display("FAIL sb_reserved act=%b exp=1", bus.oBusyA);
    else n_pass++;
    // ALU writes r7; busy must persist through the issue cycle.
    bus.iAluValid = 1'b1;
    bus.iAluAddr  = 5'd7;
    bus.iAluData  = 32'h0000_0777;
    #1;
    n_total++;
    if (bus.oAluReady !== 1'b1 || bus.oBusyA !== 1'b1)
      $display("FAIL sb_issue act=%b/%b exp=1/1", bus.oAluReady, bus.oBusyA);
    else n_pass++;
    tick();
    bus.iAluValid = 1'b0;
    n_total++;
    if (bus.oBusyA !== 1'b0 || bus.oWrite !== 1'b1 || bus.oAddrC !== 5'd7)
      $display("FAIL sb_cleared act=%b/%b/%0d exp=0/1/7", bus.oBusyA, bus.oWrite, bus.oAddrC);
    else n_pass++;
    // Reserve and write-back of r7 in the same cycle: reservation wins.
    bus.iAluValid = 1'b1;
    bus.iRsvValid = 1'b1;
    bus.iRsvAddr  = 5'd7;
    tick();
    bus.iAluValid = 1'b0;
    bus.iRsvValid = 1'b0;
    n_total++;
    if (bus.oBusyA !== 1'b1 || bus.oBusyB !== 1'b1)
      $display("FAIL sb_set_wins act=%b/%b exp=1/1", bus.oBusyA, bus.oBusyB);
    else n_pass++;
    bus.iAluValid = 1'b1;
    tick();
    clr_inputs();
  endtask

  task automatic test_stall();
    bus.iStall    = 1'b1;
    bus.iAluValid = 1'b1;
    bus.iAluAddr  = 5'd9;
    bus.iAluData  = 32'h0000_0099;
    bus.iMemValid = 1'b1;
    bus.iMemAddr  = 5'd10;
    bus.iMemData  = 32'h0000_00AA;
    bus.iAddrA    = 5'd9;
    bus.iRsvValid = 1'b1;
    bus.iRsvAddr  = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({bus.oLnkReady, bus.oMemReady, bus.oAluReady} !== 3'b000)
        $display("FAIL stall_ready[%0d] act=%b exp=000", i, {bus.oLnkReady, bus.oMemReady, bus.oAluReady});
      else n_pass++;
      tick();
      bus.iRsvValid = 1'b0;
      n_total++;
      if (bus.oWrite !== 1'b0) $display("FAIL stall_write[%0d] act=%b exp=0", i, bus.oWrite);
      else n_pass++;
    end
    n_total++;
    if (bus.oBusyA !== 1'b1) $display("FAIL stall_rsv act=%b exp=1", bus.oBusyA);
    else n_pass++;
    bus.iStall = 1'b0;
    #1;
    n_total++;
    if ({bus.oLnkReady, bus.oMemReady, bus.oAluReady} !== 3'b010)
      $display("FAIL stall_ptr act=%b exp=010", {bus.oLnkReady, bus.oMemReady, bus.oAluReady});
    else n_pass++;
    tick();
    bus.iMemValid = 1'b0;
    n_total++;
    if (bus.oWrite !== 1'b1 || bus.oAddrC !== 5'd10) $display("FAIL stall_mem act=%b/%0d exp=1/10", bus.oWrite, bus.oAddrC);
    else n_pass++;
    tick();
    bus.iAluValid = 1'b0;
    n_total++;
    if (bus.oWrite !== 1'b1 || bus.oAddrC !== 5'd9 || bus.oBusyA !== 1'b0)
      $display("FAIL stall_alu act=%b/%0d/%b exp=1/9/0", bus.oWrite, bus.oAddrC, bus.oBusyA);
    else n_pass++;
    clr_inputs();
  endtask

  task automatic test_async_reset();
    bus.iAluValid = 1'b1;
    bus.iAluAddr  = 5'd3;
    bus.iAluData  = 32'h3333_3333;
    bus.iRsvValid = 1'b1;
    bus.iRsvAddr  = 5'd12;
    tick();
    clr_inputs();
    bus.iAddrA = 5'd12;
    #1;
    n_total++;
    if (bus.oWrite !== 1'b1 || bus.oBusyA !== 1'b1) $display("FAIL ar_pre act=%b/%b exp=1/1", bus.oWrite, bus.oBusyA);
    else n_pass++;
    nRst = 1'b0;
    #1;
    n_total++;
    if (bus.oWrite !== 1'b0 || bus.oAddrC !== 5'd0 || bus.oRegC !== 32'd0)
      $display("FAIL ar_outputs act=%b/%0d/%h exp=0/0/0", bus.oWrite, bus.oAddrC, bus.oRegC);
    else n_pass++;
    n_total++;
    if (bus.oBusyA !== 1'b0) $display("FAIL ar_busy act=%b exp=0", bus.oBusyA);
    else n_pass++;
    nRst = 1'b1;
    bus.iAluValid = 1'b1;
    bus.iAluAddr  = 5'd4;
    bus.iAluData  = 32'h4444_4444;
    bus.iMemValid = 1'b1;
    bus.iMemAddr  = 5'd6;
    bus.iMemData  = 32'h6666_6666;
    #1;
    n_total++;
    if ({bus.oLnkReady, bus.oMemReady, bus.oAluReady} !== 3'b001)
      $display("FAIL ar_first_grant act=%b exp=001", {bus.oLnkReady, bus.oMemReady, bus.oAluReady});
    else n_pass++;
    tick();
    bus.iAluValid = 1'b0;
    n_total++;
    if (bus.oWrite !== 1'b1 || bus.oAddrC !== 5'd4 || bus.oRegC !== 32'h4444_4444)
      $display("FAIL ar_first_write act=%b/%0d/%h exp=1/4/44444444", bus.oWrite, bus.oAddrC, bus.oRegC);
    else n_pass++;
    tick();
    clr_inputs();
  endtask

  initial begin
    nRst = 1'b0;
    clr_inputs();
    test_reset();
    test_single_alu();
    test_contention();
    test_r0();
    test_scoreboard();
    test_stall();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
